sum_nb_seq: RTL and testbench
=============================

# sum_nb_seq

Parametrised multi-cycle N-bit adder/subtractor, the next generation of the lab's 4-bit ripple-carry adder. It processes operands CHUNK bits per clock through a chunked ripple-carry datapath with a registered inter-chunk carry, and adds subtract mode, signed-overflow detection and a start/busy/done handshake. It sits between an operand source (register file or test controller) and any consumer that samples the registered result on `done`.

## Interface

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥1.
- CHUNK, 4, bits added per clock; WIDTH % CHUNK must be 0, otherwise elaboration fails. NCH = WIDTH/CHUNK.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; accepted only in IDLE.
- sub  input  1  0 = A+B, 1 = A−B; sampled with start.
- A  input  WIDTH  operand A, unsigned or two's complement; sampled with start.
- B  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- So  output  WIDTH  registered result.
- Co  output  1  carry out of the MSB. In sub mode, 1 = no borrow.
- V  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation

- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - latch A into the A shift register.
  - latch B XOR {WIDTH{sub}} into the B shift register.
  - carry register ← sub.
  - chunk counter ← 0; go to RUN.
- IDLE, start=0: hold.
- RUN, each cycle:
  - add the low CHUNK bits of both shift registers plus the carry register using a per-bit ripple chain.
  - shift the CHUNK-bit sum into the partial-result register from the MSB side; shift both operand registers right by CHUNK.
  - carry register ← chunk carry out; counter++.
- RUN, last chunk (counter = NCH−1):
  - capture the carry into the MSB from the ripple chain.
  - So ← final partial result; Co ← chunk carry out; V ← carry-into-MSB XOR Co.
  - go to DONE.
- DONE: done=1 for one cycle, then IDLE unconditionally.
- start in RUN or DONE is ignored; no queuing.
- A, B and sub changing after acceptance has no effect on the operation in flight.
- So, Co and V change only at completion. They hold their values through IDLE until the next completion.
- CHUNK = WIDTH: NCH = 1, one RUN cycle.
- CHUNK = 1: bit-serial, NCH = WIDTH.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing

- Reset (rst_n low, any time, asynchronous):
  - state IDLE; busy=0, done=0, So=0, Co=0, V=0.
  - internal registers and counter cleared.
  - an operation in flight is aborted; no done is produced.
- After rst_n deasserts, the first rising edge with start=1 is accepted.
- start accepted at edge t0 → busy=1 after t0.
- Chunk k (k = 0..NCH−1) is computed at edge t(k+1).
- At edge tNCH: So, Co and V update; busy=0; done=1.
- At edge tNCH+1: done=0; state is IDLE.
- Latency from accepting edge to done high: NCH cycles. Throughput: one operation per NCH+2 cycles, because start is accepted again at edge tNCH+2.
- busy and done are never high simultaneously.

## Test plan

- Reset: assert rst_n=0 mid-RUN → busy=0, done=0, So=0, Co=0, V=0 immediately (asynchronously); no done after release.
- WIDTH=16, CHUNK=4, add A=0x1234, B=0x0FCD → So=0x2201, Co=0, V=0. done rises exactly 4 edges after start, busy high for 4 cycles.
- Carry and overflow, add:
  - A=0xFFFF, B=0x0001 → So=0x0000, Co=1, V=0.
  - A=0x7FFF, B=0x0001 → So=0x8000, Co=0, V=1.
- Subtract:
  - A=0x8000, B=0x0001 → So=0x7FFF, Co=1, V=1.
  - A=0x0003, B=0x0005 → So=0xFFFE, Co=0, V=0.
  - A=B=0x5A5A → So=0x0000, Co=1.
- Handshake:
  - start held high during RUN and DONE, with A, B and sub changed mid-operation → the first result is unaffected, one done pulse is produced, and the next operation starts only from IDLE.
  - So holds its value while idle.
- Parameter sweep (CHUNK ∈ {1, 2, 4, 8, 16}, WIDTH=16), random A, B and sub → So, Co and V match the reference model. Latency is exactly 16/CHUNK cycles.

Source files
------------

// File: rtl/sum_nb_seq.sv
// sum_nb_seq: multi-cycle chunked ripple-carry adder/subtractor with start/busy/done handshake
//   clk, rst_n      : clock, async active-low reset
//   start, sub      : request (taken in IDLE), 0=A+B 1=A-B
//   A, B            : WIDTH-bit operands, sampled with start
//   busy, done      : RUN indicator, one-cycle completion pulse
//   So, Co, V       : registered result, MSB carry-out (1 = no borrow in sub), signed overflow
module sum_nb_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] So,
  output logic             Co,
  output logic             V
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  if (WIDTH < 1 || WIDTH % CHUNK != 0) begin : g_bad_params
    $error("sum_nb_seq: WIDTH must be >=1 and a multiple of CHUNK");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d, so_q, so_d;
  logic c_q, c_d, co_q, co_d, v_q, v_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CHUNK+1:0] add_r;
  // Ripple chain kept inside a function so the carry vector is local; returns {carry into top bit, carry out, sum}.
  function automatic logic [CHUNK+1:0] add_chunk(input logic [CHUNK-1:0] a, input logic [CHUNK-1:0] b, input logic cin);
    logic [CHUNK:0] c;
    logic [CHUNK-1:0] s;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    return {c[CHUNK-1], c[CHUNK], s};
  endfunction
  assign add_r = add_chunk(a_q[CHUNK-1:0], b_q[CHUNK-1:0], c_q);
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    p_d = p_q;
    c_d = c_q;
    cnt_d = cnt_q;
    so_d = so_q;
    co_d = co_q;
    v_d = v_q;
    case (state_q)
      IDLE: if (start) begin
        a_d = A;
        b_d = B ^ {WIDTH{sub}};
        c_d = sub;
        cnt_d = '0;
        state_d = RUN;
      end
      RUN: begin
        a_d = a_q >> CHUNK;
        b_d = b_q >> CHUNK;
        // Sum chunks enter from the MSB side so after NCH shifts chunk 0 sits at the LSB.
        p_d = (p_q >> CHUNK) | (WIDTH'(add_r[CHUNK-1:0]) << (WIDTH - CHUNK));
        c_d = add_r[CHUNK];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NCH - 1)) begin
          so_d = p_d;
          co_d = add_r[CHUNK];
          v_d = add_r[CHUNK+1] ^ add_r[CHUNK];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
      c_q <= 1'b0;
      cnt_q <= '0;
      so_q <= '0;
      co_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      p_q <= p_d;
      c_q <= c_d;
      cnt_q <= cnt_d;
      so_q <= so_d;
      co_q <= co_d;
      v_q <= v_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign So = so_q;
  assign Co = co_q;
  assign V = v_q;
endmodule

// File: tb/tb_sum_nb_seq.sv
// tb_sum_nb_seq: directed/self-checking bench for sum_nb_seq across CHUNK = 1,2,4,8,16 at WIDTH 16
module tb_sum_nb_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic busy_w [5], done_w [5], co_w [5], v_w [5];
  logic [15:0] so_w [5];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 5; g++) begin : g_dut
    sum_nb_seq #(.WIDTH(16), .CHUNK(1 << g)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .A(A), .B(B),
      .busy(busy_w[g]), .done(done_w[g]), .So(so_w[g]), .Co(co_w[g]), .V(v_w[g])
    );
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [15:0] bx;
    logic [16:0] r;
    bx = b ^ {16{s}};
    r = {1'b0, a} + {1'b0, bx} + 17'(s);
    return {(a[15] == bx[15]) && (r[15] != a[15]), r[16], r[15:0]};
  endfunction
  // Start one op on all instances and watch every one for 20 cycles.
  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [17:0] e;
    int lat [5], bc [5], dc [5];
    logic ovl;
    e = ref_op(a, b, s);
    ovl = 1'b0;
    for (int i = 0; i < 5; i++) begin lat[i] = 0; bc[i] = 0; dc[i] = 0; end
    A = a; B = b; sub = s; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      for (int i = 0; i < 5; i++) begin
        if (busy_w[i]) bc[i]++;
        if (busy_w[i] && done_w[i]) ovl = 1'b1;
        if (done_w[i]) begin
          dc[i]++;
          lat[i] = c;
          chk($sformatf("so c%0d %h%s%h", 1 << i, a, s ? "-" : "+", b), 32'(so_w[i]), 32'(e[15:0]));
          chk($sformatf("co c%0d %h%s%h", 1 << i, a, s ? "-" : "+", b), 32'(co_w[i]), 32'(e[16]));
          chk($sformatf("v c%0d %h%s%h", 1 << i, a, s ? "-" : "+", b), 32'(v_w[i]), 32'(e[17]));
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("latency c%0d", 1 << i), 32'(lat[i]), 32'(16 >> i));
      chk($sformatf("busy cycles c%0d", 1 << i), 32'(bc[i]), 32'(16 >> i));
      chk($sformatf("done pulses c%0d", 1 << i), 32'(dc[i]), 32'd1);
    end
    chk("busy&done", 32'(ovl), 32'd0);
  endtask
  initial begin
    int dc;
    #12;
    chk("rst busy", 32'(busy_w[2]), 32'd0);
    chk("rst done", 32'(done_w[2]), 32'd0);
    chk("rst So", 32'(so_w[2]), 32'd0);
    chk("rst Co", 32'(co_w[2]), 32'd0);
    chk("rst V", 32'(v_w[2]), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    op(16'h1234, 16'h0FCD, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0);
    op(16'h7FFF, 16'h0001, 1'b0);
    op(16'h8000, 16'h0001, 1'b1);
    op(16'h0003, 16'h0005, 1'b1);
    op(16'h5A5A, 16'h5A5A, 1'b1);
    for (int k = 0; k < 6; k++) op(16'($urandom), 16'($urandom), 1'($urandom));
    // hand-computed spot checks on the CHUNK=4 instance
    op(16'h8000, 16'h0001, 1'b1);
    chk("hand 8000-1 So", 32'(so_w[2]), 32'h7FFF);
    chk("hand 8000-1 Co", 32'(co_w[2]), 32'd1);
    chk("hand 8000-1 V", 32'(v_w[2]), 32'd1);
    op(16'h0003, 16'h0005, 1'b1);
    chk("hand 3-5 So", 32'(so_w[2]), 32'hFFFE);
    chk("hand 3-5 Co", 32'(co_w[2]), 32'd0);
    // start held through RUN/DONE with operands changing mid-flight
    @(negedge clk);
    A = 16'h1234; B = 16'h0FCD; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1 A = 16'hFFFF; B = 16'hFFFF; sub = 1'b1;
    dc = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (done_w[2] && c < 10) dc++;
      if (c == 4) chk("hs first So", 32'(so_w[2]), 32'h2201);
      if (c == 4) chk("hs first done", 32'(done_w[2]), 32'd1);
      if (c == 5) chk("hs idle busy", 32'(busy_w[2]), 32'd0);
      if (c == 6) begin chk("hs restart busy", 32'(busy_w[2]), 32'd1); start = 1'b0; end
      if (c == 10) begin
        chk("hs second So", 32'(so_w[2]), 32'h0000);
        chk("hs second Co", 32'(co_w[2]), 32'd1);
        chk("hs second done", 32'(done_w[2]), 32'd1);
      end
    end
    chk("hs done pulses", 32'(dc), 32'd1);
    repeat (30) @(posedge clk);
    @(negedge clk);
    op(16'h1234, 16'h0FCD, 1'b0);
    repeat (10) @(posedge clk);
    #1 chk("hold So", 32'(so_w[2]), 32'h2201);
    // asynchronous reset mid-RUN
    @(negedge clk);
    A = 16'hFFFF; B = 16'h0001; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("async rst busy", 32'(busy_w[2]), 32'd0);
    chk("async rst done", 32'(done_w[2]), 32'd0);
    chk("async rst So", 32'(so_w[2]), 32'd0);
    chk("async rst Co", 32'(co_w[2]), 32'd0);
    chk("async rst V", 32'(v_w[2]), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    dc = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) if (done_w[i] || busy_w[i]) dc++;
    end
    chk("no activity after reset", 32'(dc), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
